// File: rtl/interrupt_arbiter_pkg.sv
// Shared types for the interrupt arbiter: privilege levels, CSR views, FSM states and cause codes.
package RafiTypes;

    typedef enum logic [1:0] {
        User       = 2'd0,
        Supervisor = 2'd1,
        Reserved   = 2'd2,
        Machine    = 2'd3
    } Privilege;

    typedef struct packed {
        logic [27:0] other;
        logic        mie;
        logic        wpri2;
        logic        sie;
        logic        uie;
    } csr_xstatus_t;

    typedef struct packed {
        logic [19:0] reserved;
        logic meip; logic wpri10; logic seip; logic ueip;
        logic mtip; logic wpri6;  logic stip; logic utip;
        logic msip; logic wpri2;  logic ssip; logic usip;
    } csr_xip_t;

    typedef struct packed {
        logic [19:0] reserved;
        logic meie; logic wpri10; logic seie; logic ueie;
        logic mtie; logic wpri6;  logic stie; logic utie;
        logic msie; logic wpri2;  logic ssie; logic usie;
    } csr_xie_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLDOFF = 2'd2
    } InterruptArbiterState;

    localparam logic [3:0] USI = 4'd0;
    localparam logic [3:0] SSI = 4'd1;
    localparam logic [3:0] MSI = 4'd3;
    localparam logic [3:0] UTI = 4'd4;
    localparam logic [3:0] STI = 4'd5;
    localparam logic [3:0] MTI = 4'd7;
    localparam logic [3:0] UEI = 4'd8;
    localparam logic [3:0] SEI = 4'd9;
    localparam logic [3:0] MEI = 4'd11;

    // Implemented cause bits: 0,1,3,4,5,7,8,9,11.
    localparam logic [11:0] IRQ_IMPL_MASK = 12'b1011_1011_1011;

    function automatic Privilege code_target(input logic [3:0] code);
        case (code)
            MSI, MTI, MEI: code_target = Machine;
            SSI, STI, SEI: code_target = Supervisor;
            default:       code_target = User;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_arbiter_sync.sv
// Two-flop synchronizer for one asynchronous level input; output follows input after 2 clk edges.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/interrupt_arbiter.sv
// Picks the highest-priority enabled pending interrupt and presents it to the pipeline with a
// valid/ack handshake; after an ack it holds off two cycles so the CSR trap update settles.
module interrupt_arbiter
    import RafiTypes::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   irqExternal,
    input  Privilege     privilege,
    input  csr_xstatus_t status,
    input  csr_xip_t     ip,
    input  csr_xie_t     ie,
    output logic [2:0]   irqSync,
    output logic         interruptValid,
    output logic [3:0]   interruptCode,
    output Privilege     interruptTargetPriv,
    input  logic         interruptAck
);

    for (genvar g = 0; g < 3; g++) begin : g_sync
        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (irqExternal[g]),
            .q_o (irqSync[g])
        );
    end

    logic [31:0] ip_vec;
    logic [31:0] ie_vec;
    logic [11:0] pending;
    logic [11:0] level_mask;
    logic [11:0] active;
    logic        any_active;
    logic        m_en;
    logic        s_en;
    logic        u_en;
    logic [3:0]  sel_code;
    logic        unused_csr;

    assign ip_vec  = ip;
    assign ie_vec  = ie;
    assign pending = ip_vec[11:0] & ie_vec[11:0] & IRQ_IMPL_MASK;

    // A level is taken when running below it, or at it with its xIE set.
    assign m_en = (privilege != Machine) || status.mie;
    assign s_en = (privilege == User) || ((privilege == Supervisor) && status.sie);
    assign u_en = (privilege == User) && status.uie;

    assign level_mask = {m_en, 1'b0, s_en, u_en, m_en, 1'b0, s_en, u_en, m_en, 1'b0, s_en, u_en};
    assign active     = pending & level_mask;
    assign any_active = |active;
    assign unused_csr = ^{ip_vec[31:12], ie_vec[31:12], status.other, status.wpri2};

    always_comb begin
        sel_code = USI;
        if      (active[MEI]) sel_code = MEI;
        else if (active[MSI]) sel_code = MSI;
        else if (active[MTI]) sel_code = MTI;
        else if (active[SEI]) sel_code = SEI;
        else if (active[SSI]) sel_code = SSI;
        else if (active[STI]) sel_code = STI;
        else if (active[UEI]) sel_code = UEI;
        else if (active[USI]) sel_code = USI;
        else if (active[UTI]) sel_code = UTI;
    end

    InterruptArbiterState state_q, state_d;
    logic [3:0]           code_q, code_d;
    Privilege             target_q, target_d;
    logic                 hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= 4'd0;
            target_q   <= Machine;
            hold_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            target_q   <= target_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        target_d   = target_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_active) begin
                    state_d  = REQUEST;
                    code_d   = sel_code;
                    target_d = code_target(sel_code);
                end
            end
            REQUEST: begin
                // Ack wins over withdrawal or re-prioritisation: the acked code is frozen.
                if (interruptAck) begin
                    state_d    = HOLDOFF;
                    hold_cnt_d = 1'b0;
                end else if (any_active) begin
                    code_d   = sel_code;
                    target_d = code_target(sel_code);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (hold_cnt_q) begin
                    state_d    = IDLE;
                    hold_cnt_d = 1'b0;
                end else begin
                    hold_cnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        interruptValid      = (state_q == REQUEST);
        interruptCode       = code_q;
        interruptTargetPriv = target_q;
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: hand-computed vectors for priority, enables, handshake and reset.
module tb_interrupt_arbiter;
    import RafiTypes::*;

    logic         clk;
    logic         rst;
    logic [2:0]   irqExternal;
    Privilege     privilege;
    csr_xstatus_t status;
    csr_xip_t     ip;
    csr_xip_t     ip_man;
    csr_xie_t     ie;
    logic [2:0]   irqSync;
    logic         interruptValid;
    logic [3:0]   interruptCode;
    Privilege     interruptTargetPriv;
    logic         interruptAck;
    logic         use_sync;
    logic [31:0]  sync_vec;

    int checks = 0;
    int errors = 0;

    interrupt_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .irqExternal         (irqExternal),
        .privilege           (privilege),
        .status              (status),
        .ip                  (ip),
        .ie                  (ie),
        .irqSync             (irqSync),
        .interruptValid      (interruptValid),
        .interruptCode       (interruptCode),
        .interruptTargetPriv (interruptTargetPriv),
        .interruptAck        (interruptAck)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MEIP/MTIP/MSIP fed back from the synchronizer outputs.
    assign sync_vec = {20'd0, irqSync[0], 3'b000, irqSync[1], 3'b000, irqSync[2], 3'b000};
    always_comb ip = use_sync ? csr_xip_t'(sync_vec) : ip_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] c, input Privilege p);
        check({tag, "_valid"}, 32'(interruptValid), 32'(v));
        check({tag, "_code"}, 32'(interruptCode), 32'(c));
        check({tag, "_target"}, 32'(interruptTargetPriv), 32'(p));
    endtask

    initial begin
        rst          = 1'b1;
        irqExternal  = 3'b000;
        privilege    = Machine;
        status       = '0;
        ip_man       = '0;
        ie           = '0;
        interruptAck = 1'b0;
        use_sync     = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 4'd0, Machine);
        check("reset_sync", 32'(irqSync), 32'd0);
        rst = 1'b0;

        // External line through the synchronizer into MEIP.
        use_sync    = 1'b1;
        ie.meie     = 1'b1;
        status.mie  = 1'b1;
        privilege   = Machine;
        irqExternal = 3'b001;
        tick();
        check("sync_1cyc", 32'(irqSync), 32'd0);
        tick();
        check("sync_2cyc", 32'(irqSync), 32'd1);
        check("ext_not_yet", 32'(interruptValid), 32'd0);
        tick();
        check_out("ext_mei", 1'b1, MEI, Machine);
        irqExternal = 3'b000;
        repeat (4) tick();
        check("ext_drop", 32'(interruptValid), 32'd0);

        // MSI outranks MTI.
        use_sync   = 1'b0;
        ie         = '0;
        ip_man     = '0;
        ip_man.msip = 1'b1; ip_man.mtip = 1'b1;
        ie.msie     = 1'b1; ie.mtie     = 1'b1;
        tick();
        check_out("msi_vs_mti", 1'b1, MSI, Machine);
        ip_man = '0;
        tick();
        check("msi_withdrawn", 32'(interruptValid), 32'd0);

        // From U-mode: M beats S, then S takes over.
        privilege   = User;
        status      = '0;
        ie          = '0;
        ip_man.stip = 1'b1; ip_man.mtip = 1'b1;
        ie.stie     = 1'b1; ie.mtie     = 1'b1;
        tick();
        check_out("m_beats_s", 1'b1, MTI, Machine);
        ip_man.mtip = 1'b0;
        tick();
        check_out("s_after_m", 1'b1, STI, Supervisor);

        // Ack together with a higher-priority arrival: STI is frozen through holdoff.
        ip_man.meip  = 1'b1;
        ie.meie      = 1'b1;
        interruptAck = 1'b1;
        tick();
        interruptAck = 1'b0;
        check_out("hold1", 1'b0, STI, Supervisor);
        tick();
        check_out("hold2", 1'b0, STI, Supervisor);
        for (int i = 0; i < 4 && !interruptValid; i++) tick();
        check_out("after_hold", 1'b1, MEI, Machine);

        // Withdrawal, then an ack pulse while idle must not enter holdoff.
        ip_man = '0;
        tick();
        check("withdraw", 32'(interruptValid), 32'd0);
        interruptAck = 1'b1;
        tick();
        interruptAck = 1'b0;
        check("idle_ack", 32'(interruptValid), 32'd0);
        ip_man.stip = 1'b1;
        tick();
        check_out("post_idle_ack", 1'b1, STI, Supervisor);

        // U-level ordering 8 > 0 > 4 with UIE.
        status.uie  = 1'b1;
        ie          = '0;
        ip_man      = '0;
        ip_man.ueip = 1'b1; ip_man.usip = 1'b1; ip_man.utip = 1'b1;
        ie.ueie     = 1'b1; ie.usie     = 1'b1; ie.utie     = 1'b1;
        tick();
        check_out("u_uei", 1'b1, UEI, User);
        ip_man.ueip = 1'b0;
        tick();
        check_out("u_usi", 1'b1, USI, User);
        ip_man.usip = 1'b0;
        tick();
        check_out("u_uti", 1'b1, UTI, User);

        // S-mode with SIE=0 masks SEI; setting SIE releases it.
        irqExternal = 3'b111;
        privilege   = Supervisor;
        status      = '0;
        ie          = '0;
        ip_man      = '0;
        ip_man.seip = 1'b1;
        ie.seie     = 1'b1;
        tick();
        check("sie0_a", 32'(interruptValid), 32'd0);
        tick();
        check("sie0_b", 32'(interruptValid), 32'd0);
        status.sie = 1'b1;
        tick();
        check_out("sie1", 1'b1, SEI, Supervisor);
        check("sync_all", 32'(irqSync), 32'd7);

        // Asynchronous reset in the middle of REQUEST.
        #3 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 4'd0, Machine);
        check("async_rst_sync", 32'(irqSync), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check_out("post_rst", 1'b1, SEI, Supervisor);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-003 SHALL have port irqExternal, input, 3 bits: asynchronous external lines; bit0 = machine external, bit1 = machine timer, bit2 = machine software.
REQ-004 SHALL have port privilege, input, Privilege: current privilege from the CSR unit.
REQ-005 SHALL have port status, input, csr_xstatus_t; it uses only UIE (bit0), SIE (bit1) and MIE (bit3).
REQ-006 SHALL have ports ip and ie, input, csr_xip_t/csr_xie_t; it uses only bits 0,1,3,4,5,7,8,9,11.
REQ-007 SHALL have port irqSync, output, 3 bits: synchronized irqExternal, fed to the CSR unit as MEIP/MTIP/MSIP.
REQ-008 SHALL have port interruptValid, output, 1 bit: an interrupt request to the pipeline.
REQ-009 SHALL have port interruptCode, output, 4 bits: the cause code (ip bit index).
REQ-010 SHALL have port interruptTargetPriv, output, Privilege: the trap target privilege.
REQ-011 SHALL have port interruptAck, input, 1 bit: the pipeline has committed the trap for the presented code.

Function
REQ-012 SHALL pass each irqExternal bit through two flops; irqSync is high 2 cycles after the input edge.
REQ-013 SHALL form pending = ip & ie, restricted to the bits in REQ-006.
REQ-014 SHALL enable a bit with target level x when privilege < x, or when privilege == x and status.xIE = 1; there is no delegation, so M bits (3,7,11) target M, S bits (1,5,9) target S, and U bits (0,4,8) target U.
REQ-015 SHALL use fixed priority, highest first: 11, 3, 7, 9, 1, 5, 8, 0, 4.
REQ-016 SHALL implement a state machine with states IDLE, REQUEST and HOLDOFF.
REQ-017 IDLE: SHALL move to REQUEST on the next edge when any enabled pending bit exists.
REQ-018 REQUEST: interruptValid SHALL be 1 and interruptCode/interruptTargetPriv SHALL be registered.
REQ-019 REQUEST: SHALL re-evaluate the registered code each cycle, so a higher-priority arrival replaces it the next cycle.
REQ-020 REQUEST: if no enabled pending bit remains and ack is 0, SHALL return to IDLE with valid 0 on the next cycle.
REQ-021 REQUEST: when interruptAck = 1, SHALL go to HOLDOFF and freeze the code; ack takes precedence over a simultaneous withdrawal or code change.
REQ-022 SHALL ignore interruptAck while interruptValid = 0.
REQ-023 HOLDOFF: SHALL last exactly 2 cycles with valid 0, then go to IDLE, so the CSR update of status/privilege becomes visible.
REQ-024 Latency: an enabled pending bit in cycle N SHALL give interruptValid = 1 in cycle N+1.

Reset
REQ-025 On rst: state SHALL be IDLE, synchronizer flops 0, irqSync 0, interruptValid 0, interruptCode 0, interruptTargetPriv = Machine, holdoff counter 0.
REQ-026 Reset asserted in any state, including mid-REQUEST, SHALL drop interruptValid immediately and asynchronously.

Structure
REQ-027 The InterruptArbiterState enum and the interrupt code constants (USI=0 ... MEI=11) SHALL be defined in RafiTypes.
REQ-028 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, instantiated once per irqExternal bit.

Verification
REQ-029 irqExternal[0] rises, ie.MEIE=1, status.MIE=1, privilege=M, ip fed from irqSync -> irqSync[0] goes high after 2 cycles; valid=1, code=11, target=M one cycle after pending.
REQ-030 privilege=U, status=0, ip bits 5 and 7 set and enabled -> code=7 (M beats S); clear bit 7 -> code=5, target=S the next cycle.
REQ-031 privilege=S, SIE=0, only bit 9 pending and enabled -> valid stays 0; set SIE=1 -> valid=1, code=9.
REQ-032 Valid with code 5, then bit 11 arrives and ack=1 in the same cycle -> code 5 is frozen, HOLDOFF for 2 cycles with valid 0, then REQUEST with code 11.
REQ-033 Pending removed before ack -> valid drops the next cycle; ack pulse while idle -> no state change.
REQ-034 rst pulsed during REQUEST -> valid=0 immediately, all outputs at reset values, state IDLE.
